// File: rtl/imem_responder.sv
// Instruction-memory responder: synchronous instruction RAM with a one-cycle
// read stage feeding a small in-order {address, instruction} queue for decode.
// Fetch is back-pressured by reserving queue space for the read in flight,
// a branch flush discards all pending work, and a load port fills the RAM.
module imem_responder #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 9,
  parameter int QDEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid_i,
  input  logic [ADDR_W-1:0]          req_addr_i,
  output logic                       req_ready_o,
  input  logic                       flush_i,
  output logic                       instr_valid_o,
  output logic [INSTR_W-1:0]         instr_o,
  output logic [ADDR_W-1:0]          instr_addr_o,
  input  logic                       instr_ready_i,
  input  logic                       load_en_i,
  input  logic [ADDR_W-1:0]          load_addr_i,
  input  logic [INSTR_W-1:0]         load_data_i,
  output logic [$clog2(QDEPTH):0]    count_o
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] QDEPTH_C = CNT_W'(QDEPTH);

  logic [INSTR_W-1:0] mem [2**ADDR_W];

  logic               s1_valid;
  logic [ADDR_W-1:0]  s1_addr;
  logic [INSTR_W-1:0] s1_data;

  logic [INSTR_W-1:0] q_data [QDEPTH];
  logic [ADDR_W-1:0]  q_addr [QDEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic accept;
  logic push;
  logic pop;

  // Handshakes and head-of-queue outputs; the ready term counts the read in
  // flight so a push can never find the queue full.
  always_comb begin
    req_ready_o   = rst_n && !flush_i && ((count + CNT_W'(s1_valid)) < QDEPTH_C);
    instr_valid_o = rst_n && (count != '0);
    count_o       = rst_n ? count : '0;
    instr_o       = q_data[rd_ptr];
    instr_addr_o  = q_addr[rd_ptr];
    accept        = req_valid_i && req_ready_o;
    push          = s1_valid && !flush_i;
    pop           = instr_valid_o && instr_ready_i && !flush_i;
  end

  // Program-load writes; RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (load_en_i) mem[load_addr_i] <= load_data_i;
  end

  // Read stage data: non-blocking read sees the pre-load word (read-before-write).
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_data <= mem[req_addr_i];
      s1_addr <= req_addr_i;
    end
  end

  // Read stage valid; a flush can never coincide with an accept.
  always_ff @(posedge clk) begin
    if (!rst_n) s1_valid <= 1'b0;
    else        s1_valid <= accept;
  end

  // Queue storage writes; entries are qualified by count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= s1_data;
      q_addr[wr_ptr] <= s1_addr;
    end
  end

  // Queue pointers and occupancy; flush empties the queue and overrides push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a RAM model plus an expected-output queue
// filled on each accepted request and drained on each decode pop.
module tb_imem_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid_i;
  logic [7:0] req_addr_i;
  logic       req_ready_o;
  logic       flush_i;
  logic       instr_valid_o;
  logic [8:0] instr_o;
  logic [7:0] instr_addr_o;
  logic       instr_ready_i;
  logic       load_en_i;
  logic [7:0] load_addr_i;
  logic [8:0] load_data_i;
  logic [2:0] count_o;

  int total = 0;
  int bad   = 0;
  logic acc;
  int   n_acc;
  logic [7:0] next_addr;

  logic [8:0]  model_mem [256];
  logic [16:0] exp_q [$];

  imem_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid_i),
    .req_addr_i    (req_addr_i),
    .req_ready_o   (req_ready_o),
    .flush_i       (flush_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_addr_o  (instr_addr_o),
    .instr_ready_i (instr_ready_i),
    .load_en_i     (load_en_i),
    .load_addr_i   (load_addr_i),
    .load_data_i   (load_data_i),
    .count_o       (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: sample handshakes just before the edge, update the scoreboard
  // and RAM model, then advance past the edge.
  task automatic step();
    logic acc_now;
    logic pop_now;
    logic [16:0] ent;
    #1;
    acc_now = req_valid_i && req_ready_o;
    pop_now = instr_valid_o && instr_ready_i;
    if (!rst_n || flush_i) begin
      exp_q.delete();
    end else begin
      if (pop_now) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          ent = exp_q.pop_front();
          chk("sb_addr", 32'(instr_addr_o), 32'(ent[16:9]));
          chk("sb_data", 32'(instr_o), 32'(ent[8:0]));
        end
      end
      if (acc_now) exp_q.push_back({req_addr_i, model_mem[req_addr_i]});
    end
    if (load_en_i) model_mem[load_addr_i] = load_data_i;
    acc = acc_now;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    req_valid_i   = 1'b0;
    instr_ready_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (exp_q.size() == 0 && !instr_valid_o) break;
      step();
    end
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_count0"}, 32'(count_o), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; flush_i = 1'b0;
    instr_ready_i = 1'b0; load_en_i = 1'b0; load_addr_i = '0; load_data_i = '0;
    acc = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = 'x;
    step(); step();
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd0);

    // Program load (held in reset; load ignores reset)
    for (int i = 0; i < 256; i++) begin
      load_en_i   = 1'b1;
      load_addr_i = 8'(i);
      load_data_i = (i < 8) ? 9'(i + 'h40) : 9'((i * 37 + 11) & 'h1FF);
      step();
    end
    load_en_i = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready_o), 32'd1);

    // Back-to-back stream 0..7 with decode always ready
    instr_ready_i = 1'b1;
    req_valid_i   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_addr_i = 8'(i);
      #1;
      chk("t1_ready", 32'(req_ready_o), 32'd1);
      step();
      if (i == 0) chk("t1_lat_edge1", 32'(instr_valid_o), 32'd0);
      if (i == 1) begin
        chk("t1_lat_edge2", 32'(instr_valid_o), 32'd1);
        chk("t1_first_addr", 32'(instr_addr_o), 32'd0);
        chk("t1_first_data", 32'(instr_o), 32'h40);
      end
      chk("t1_count_le2", 32'(count_o <= 3'd2), 32'd1);
    end
    drain("t1");

    // Fill with decode stalled: exactly four accepts
    instr_ready_i = 1'b0;
    req_valid_i   = 1'b1;
    next_addr     = 8'd10;
    n_acc         = 0;
    for (int i = 0; i < 8; i++) begin
      req_addr_i = next_addr;
      step();
      if (acc) begin
        n_acc++;
        next_addr++;
      end
    end
    chk("t2_accepts", 32'(n_acc), 32'd4);
    chk("t2_ready_low", 32'(req_ready_o), 32'd0);
    chk("t2_count4", 32'(count_o), 32'd4);
    chk("t2_head_addr", 32'(instr_addr_o), 32'd10);

    // Full queue, nothing in flight, decode pops: no accept this cycle
    instr_ready_i = 1'b1;
    req_addr_i    = next_addr;
    #1;
    chk("t5_ready_full", 32'(req_ready_o), 32'd0);
    step();
    chk("t5_no_accept", 32'(acc), 32'd0);
    chk("t5_count3", 32'(count_o), 32'd3);
    step();
    chk("t5_accept_next", 32'(acc), 32'd1);
    drain("t2");

    // Flush with two queued and one in flight
    instr_ready_i = 1'b0;
    req_valid_i   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr_i = 8'(8'h20 + i);
      step();
    end
    chk("t3_count2", 32'(count_o), 32'd2);
    flush_i    = 1'b1;
    req_addr_i = 8'h80;
    #1;
    chk("t3_ready_flush", 32'(req_ready_o), 32'd0);
    step();
    flush_i = 1'b0;
    chk("t3_count0", 32'(count_o), 32'd0);
    chk("t3_valid0", 32'(instr_valid_o), 32'd0);
    #1;
    chk("t3_ready_after", 32'(req_ready_o), 32'd1);
    step();
    req_valid_i = 1'b0;
    step();
    chk("t3_count1", 32'(count_o), 32'd1);
    chk("t3_head_addr", 32'(instr_addr_o), 32'h80);
    chk("t3_head_data", 32'(instr_o), 32'(model_mem[8'h80]));
    drain("t3");

    // Same-cycle load and read of address 5
    instr_ready_i = 1'b1;
    req_valid_i   = 1'b1;
    req_addr_i    = 8'd5;
    load_en_i     = 1'b1;
    load_addr_i   = 8'd5;
    load_data_i   = 9'h1AA;
    step();
    load_en_i   = 1'b0;
    req_valid_i = 1'b0;
    step();
    chk("t4_old_valid", 32'(instr_valid_o), 32'd1);
    chk("t4_old_data", 32'(instr_o), 32'h045);
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    step();
    chk("t4_new_data", 32'(instr_o), 32'h1AA);
    drain("t4");

    // Reset mid-operation with three entries queued
    instr_ready_i = 1'b0;
    req_valid_i   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr_i = 8'(i);
      step();
    end
    req_valid_i = 1'b0;
    step();
    chk("t6_count3", 32'(count_o), 32'd3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("t6_count0", 32'(count_o), 32'd0);
    chk("t6_valid0", 32'(instr_valid_o), 32'd0);
    instr_ready_i = 1'b1;
    req_valid_i   = 1'b1;
    req_addr_i    = 8'd2;
    step();
    req_valid_i = 1'b0;
    step();
    chk("t6_refetch_addr", 32'(instr_addr_o), 32'd2);
    chk("t6_refetch_data", 32'(instr_o), 32'h42);
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
